// File: rtl/hit_judge.sv
`timescale 1ns/1ps
// hit_judge: judges one-hot LED rounds against debounced player switches and keeps scores.
// Define HIT_STREAK_EN to enable the consecutive-hit streak and its bonus scoring.
module hit_judge #(
  parameter int NUM_LEDS        = 8,
  parameter int WINDOW_CYCLES   = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TIME_W          = 30,
  parameter int TOKEN_W         = 8,
  parameter int SCORE_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [NUM_LEDS-1:0] sw_in,
  output logic [TOKEN_W-1:0]  token,
  output logic                token_valid,
  output logic                hit,
  output logic                miss,
  output logic [TIME_W-1:0]   reaction_time,
  output logic [SCORE_W-1:0]  hit_count,
  output logic [SCORE_W-1:0]  miss_count,
  output logic [3:0]          streak,
  output logic                busy
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIME_W-1:0]  WIN_LAST  = TIME_W'(WINDOW_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, REPORT, WAIT_CLEAR} state_t;
  state_t state, state_next;

  logic [NUM_LEDS-1:0] sync1, sync2, deb, flip;
  logic [DB_W-1:0]     db_cnt [NUM_LEDS];

  logic [NUM_LEDS-1:0] target;
  logic [TIME_W-1:0]   counter;
  logic                verdict_hit;
  logic                led_onehot, target_flip, other_flip, give_up, decide, round_hit;
  logic [SCORE_W:0]    hit_sum;
  logic [SCORE_W-1:0]  hit_next;

  // A switch is accepted only once its synced level has differed from the
  // debounced level for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      flip  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      for (int i = 0; i < NUM_LEDS; i++) begin
        flip[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          flip[i]   <= 1'b1;
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign led_onehot  = (led_in != '0) && ((led_in & (led_in - NUM_LEDS'(1))) == '0);
  assign target_flip = |(flip & target);
  assign other_flip  = |(flip & ~target);
  assign give_up     = (counter == WIN_LAST) || (led_in == '0);
  assign decide      = (state == ARMED) && (target_flip || other_flip || give_up);
  assign round_hit   = target_flip && !other_flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (led_onehot) state_next = ARMED;
      ARMED:      if (decide) state_next = REPORT;
      REPORT:     state_next = WAIT_CLEAR;
      WAIT_CLEAR: if (led_in == '0) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    hit         = 1'b0;
    miss        = 1'b0;
    token_valid = 1'b0;
    busy        = (state != IDLE);
    if (state == REPORT) begin
      token_valid = 1'b1;
      hit         = verdict_hit;
      miss        = !verdict_hit;
    end
  end

`ifdef HIT_STREAK_EN
  logic [3:0] streak_r;

  assign hit_sum = {1'b0, hit_count} +
                   ((streak_r >= 4'd3) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
  assign streak  = streak_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_r <= '0;
    end else if (decide) begin
      if (!round_hit)             streak_r <= '0;
      else if (streak_r != 4'd15) streak_r <= streak_r + 4'd1;
    end
  end
`else
  assign hit_sum = {1'b0, hit_count} + (SCORE_W+1)'(1);
  assign streak  = '0;
`endif

  assign hit_next = (hit_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : hit_sum[SCORE_W-1:0];

  // Verdict, timing and scores are all captured on the deciding edge so they
  // appear together with the REPORT pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target        <= '0;
      counter       <= '0;
      verdict_hit   <= 1'b0;
      reaction_time <= '0;
      token         <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else if (state == IDLE) begin
      if (led_onehot) begin
        target  <= led_in;
        counter <= '0;
      end
    end else if (state == ARMED) begin
      if (decide) begin
        verdict_hit   <= round_hit;
        reaction_time <= counter;
        token         <= counter[TOKEN_W-1:0];
        if (round_hit)                    hit_count  <= hit_next;
        else if (miss_count != SCORE_MAX) miss_count <= miss_count + SCORE_W'(1);
      end else begin
        counter <= counter + TIME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
`timescale 1ns/1ps
// tb_hit_judge: directed and randomized rounds against a schedule-based model of the
// switch debounce delay and the judging rules; honours HIT_STREAK_EN when defined.
module tb_hit_judge;

  localparam int D = 4;
  localparam int W = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  led_in, sw_in;
  logic [7:0]  token;
  logic        token_valid, hit, miss, busy;
  logic [29:0] reaction_time;
  logic [7:0]  hit_count, miss_count;
  logic [3:0]  streak;

  int tests = 0;
  int fails = 0;
  int model_hits, model_misses, model_streak;

  logic [7:0] sw_sched  [128];
  logic [7:0] led_sched [128];
  logic       led_set   [128];
  logic [7:0] pred_raw  [128];

  hit_judge #(
    .NUM_LEDS(8), .WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D),
    .TIME_W(30), .TOKEN_W(8), .SCORE_W(8)
  ) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .sw_in(sw_in),
    .token(token), .token_valid(token_valid), .hit(hit), .miss(miss),
    .reaction_time(reaction_time), .hit_count(hit_count), .miss_count(miss_count),
    .streak(streak), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 128; i++) begin
      sw_sched[i]  = '0;
      led_sched[i] = '0;
      led_set[i]   = 1'b0;
    end
  endtask

  task automatic arm(input logic [7:0] mask);
    led_sched[0] = mask;
    led_set[0]   = 1'b1;
  endtask

  // Raw change driven at offset k-1-D becomes a debounced flip when counter == k.
  task automatic sched_toggle(input int bit_i, input int k);
    sw_sched[k-1-D][bit_i] = ~sw_sched[k-1-D][bit_i];
  endtask

  function automatic logic [7:0] raw_at(input int t, input logic [7:0] sw0);
    if (t < 0) return sw0;
    return pred_raw[t];
  endfunction

  // Synced level in cycle c is the raw level driven in cycle c-2; a flip happens
  // once the synced level has differed from the debounced level for D cycles.
  task automatic predict(input logic [7:0] sw0, output int kd, output logic exp_hit);
    logic [7:0] deb, cur_led, tgt, f, lv;
    logic       v, stable;
    int         i;
    for (int t = 0; t < 128; t++)
      pred_raw[t] = ((t == 0) ? sw0 : pred_raw[(t == 0) ? 0 : t-1]) ^ sw_sched[t];
    deb     = sw0;
    tgt     = led_sched[0];
    cur_led = led_sched[0];
    kd      = W - 1;
    exp_hit = 1'b0;
    for (int cnt = 0; cnt < W; cnt++) begin
      i = cnt + 1;
      f = '0;
      for (int b = 0; b < 8; b++) begin
        lv = raw_at(i - 3, sw0);
        v = lv[b];
        stable = 1'b1;
        for (int j = 1; j <= D; j++) begin
          lv = raw_at(i - j - 2, sw0);
          if (lv[b] != v) stable = 1'b0;
        end
        if (stable && v != deb[b]) begin
          f[b]   = 1'b1;
          deb[b] = v;
        end
      end
      if (led_set[i]) cur_led = led_sched[i];
      if ((f & ~tgt) != 0) begin
        kd = cnt; exp_hit = 1'b0; break;
      end else if ((f & tgt) != 0) begin
        kd = cnt; exp_hit = 1'b1; break;
      end else if (cnt == W - 1 || cur_led == 0) begin
        kd = cnt; exp_hit = 1'b0; break;
      end
    end
  endtask

  task automatic apply_stimulus(input int hold, input logic ign_en, input int ign_bit);
    int   kd, inc, hold_n;
    logic eh;
    predict(sw_in, kd, eh);
    for (int i = 0; i <= kd + 2; i++) begin
      if (i == kd + 2) begin
        if (eh) begin
          inc = 1;
`ifdef HIT_STREAK_EN
          if (model_streak >= 3) inc = 2;
          model_streak = (model_streak < 15) ? model_streak + 1 : 15;
`endif
          model_hits = (model_hits + inc > 255) ? 255 : model_hits + inc;
        end else begin
          model_misses = (model_misses < 255) ? model_misses + 1 : 255;
          model_streak = 0;
        end
        check_output("hit", 32'(hit), 32'(eh));
        check_output("miss", 32'(miss), 32'(!eh));
        check_output("token_valid", 32'(token_valid), 32'd1);
        check_output("reaction_time", 32'(reaction_time), 32'(kd));
        check_output("token", 32'(token), 32'(kd % 256));
        check_output("hit_count", 32'(hit_count), 32'(model_hits));
        check_output("miss_count", 32'(miss_count), 32'(model_misses));
        check_output("streak", 32'(streak), 32'(model_streak));
      end else begin
        check_output("no_pulse", 32'({hit, miss, token_valid}), 32'd0);
        check_output("busy_round", 32'(busy), 32'(i != 0));
      end
      if (i <= kd + 1) begin
        sw_in = sw_in ^ sw_sched[i];
        if (led_set[i]) led_in = led_sched[i];
      end
      step();
    end
    hold_n = (led_in == 0) ? 0 : hold;
    check_output("busy_wait_clear", 32'(busy), 32'd1);
    check_output("reaction_time_held", 32'(reaction_time), 32'(kd));
    if (ign_en) sw_in[ign_bit] = ~sw_in[ign_bit];
    repeat (hold_n) begin
      step();
      check_output("busy_hold", 32'(busy), 32'd1);
      check_output("no_pulse_hold", 32'({hit, miss, token_valid}), 32'd0);
    end
    led_in = '0;
    step();
    check_output("busy_idle", 32'(busy), 32'd0);
    repeat (12) begin
      step();
      check_output("no_pulse_idle", 32'({hit, miss, token_valid}), 32'd0);
    end
    check_output("hit_count_after", 32'(hit_count), 32'(model_hits));
    check_output("miss_count_after", 32'(miss_count), 32'(model_misses));
  endtask

  task automatic reset_mid_round();
    led_in = 8'h20;
    repeat (10) step();
    check_output("busy_armed", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("busy_async_rst", 32'(busy), 32'd0);
    step();
    check_output("rst_pulses", 32'({hit, miss, token_valid}), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_hit_count", 32'(hit_count), 32'd0);
    check_output("rst_miss_count", 32'(miss_count), 32'd0);
    check_output("rst_reaction_time", 32'(reaction_time), 32'd0);
    check_output("rst_token", 32'(token), 32'd0);
    check_output("rst_streak", 32'(streak), 32'd0);
    rst = 1'b0;
    led_in = '0;
    model_hits = 0; model_misses = 0; model_streak = 0;
    repeat (15) begin
      step();
      check_output("post_rst_quiet", 32'({hit, miss, token_valid, busy}), 32'd0);
    end
  endtask

  initial begin
    int idx, wrong, kind, k;
    logic [7:0] tmask;
    rst = 1'b1; led_in = '0; sw_in = '0;
    model_hits = 0; model_misses = 0; model_streak = 0;
    step(); step();
    check_output("reset_hit_count", 32'(hit_count), 32'd0);
    check_output("reset_miss_count", 32'(miss_count), 32'd0);
    check_output("reset_reaction_time", 32'(reaction_time), 32'd0);
    check_output("reset_token", 32'(token), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_pulses", 32'({hit, miss, token_valid}), 32'd0);
    check_output("reset_streak", 32'(streak), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Hit at counter 20.
    clear_sched(); arm(8'h04); sched_toggle(2, 20);
    apply_stimulus(2, 1'b0, 0);
    // Wrong switch, then a target flip during WAIT_CLEAR that must be ignored.
    clear_sched(); arm(8'h10); sched_toggle(1, 30);
    apply_stimulus(10, 1'b1, 4);
    // Pure timeout, then target flip landing exactly on the last window cycle.
    clear_sched(); arm(8'h01);
    apply_stimulus(1, 1'b0, 0);
    clear_sched(); arm(8'h01); sched_toggle(0, 99);
    apply_stimulus(1, 1'b0, 0);
    // Bouncing switch yields only one flip after it settles.
    clear_sched(); arm(8'h08);
    for (int o = 1; o <= 21; o += 2) sw_sched[o][3] = 1'b1;
    apply_stimulus(1, 1'b0, 0);
    // Multi-hot LEDs never arm a round.
    led_in = 8'h03;
    repeat (6) begin
      step();
      check_output("multi_hot_busy", 32'(busy), 32'd0);
      check_output("multi_hot_pulse", 32'({hit, miss, token_valid}), 32'd0);
    end
    led_in = '0;
    step();

    repeat (40) begin
      clear_sched();
      idx   = int'($urandom_range(0, 7));
      tmask = 8'(1 << idx);
      arm(tmask);
      kind  = int'($urandom_range(0, 4));
      k     = int'($urandom_range(D + 2, W - 1));
      wrong = (idx + int'($urandom_range(1, 7))) % 8;
      if ($urandom_range(0, 1) == 1) begin
        led_sched[3] = 8'($urandom_range(1, 255));
        led_set[3]   = 1'b1;
      end
      case (kind)
        0: sched_toggle(idx, k);
        1: sched_toggle(wrong, k);
        2: begin sched_toggle(idx, k); sched_toggle(wrong, k); end
        3: ;
        default: begin led_sched[k+1] = '0; led_set[k+1] = 1'b1; end
      endcase
      apply_stimulus(int'($urandom_range(0, 3)), 1'b0, 0);
    end

    reset_mid_round();

    // Four consecutive hits then one miss from a cleared score.
    for (int n = 0; n < 4; n++) begin
      clear_sched(); arm(8'h40); sched_toggle(6, 10 + n);
      apply_stimulus(0, 1'b0, 0);
    end
    clear_sched(); arm(8'h40); sched_toggle(5, 12);
    apply_stimulus(0, 1'b0, 0);

    // Drive the hit score into saturation, then one more hit.
    while (model_hits < 255) begin
      clear_sched(); arm(8'h02); sched_toggle(1, D + 2);
      apply_stimulus(0, 1'b0, 0);
    end
    clear_sched(); arm(8'h80); sched_toggle(7, D + 3);
    apply_stimulus(0, 1'b0, 0);
    check_output("hit_count_saturated", 32'(hit_count), 32'd255);

    reset_mid_round();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
